gat_feat_reader: RTL



---
 rtl/gat_pkg.sv | 11 +
 rtl/gat_feat_rd_fifo.sv | 49 ++++
 rtl/gat_feat_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gat_pkg.sv
// Shared GAT accelerator constants and the feature-reader state type.
package gat_pkg;
  localparam int DATA_WIDTH         = 8;
  localparam int NUM_SUBGRAPHS      = 2708;
  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);
  localparam int PACK               = 32 / DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} feat_rd_state_t;
endpackage

// File: rtl/gat_feat_rd_fifo.sv
// Small synchronous FIFO that catches BRAM returns ahead of the packer.
module gat_feat_rd_fifo #(
  parameter int  FIFO_DEPTH = 4,
  parameter int  DATA_WIDTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH + 1),
  localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [CW-1:0]         count_o
);
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      if (push_i && !do_pop)      count_q <= count_q + CW'(1);
      else if (!push_i && do_pop) count_q <= count_q - CW'(1);
    end
  end

  // The issue credit makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(push_i && !do_pop && (count_q == CW'(FIFO_DEPTH))));
endmodule

// File: rtl/gat_feat_reader.sv
// Drains the new-feature BRAM through port B and streams features packed PACK per word.
module gat_feat_reader
  import gat_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   feat_count,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  output logic                          feat_bram_enb,
  input  logic [31:0]                   feat_bram_dout,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
);
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);
  localparam int CW         = NEW_FEATURE_ADDR_W + 1;
  localparam int LW         = (PACK > 1) ? $clog2(PACK) : 1;

  feat_rd_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, issued_q, popped_q, cnt_clamp;
  logic [RD_LATENCY:1] vld_pipe_q;
  logic [PACK-1:0][DATA_WIDTH-1:0] lanes_q, word_d;
  logic [LW-1:0] lane_q;
  logic [31:0]   tdata_q;
  logic          tvalid_q, tlast_q;

  logic [FCW-1:0]        in_flight, fifo_count;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic start_acc, credit, issue, pop, last_pop, hs, active;

  assign cnt_clamp = (feat_count > CW'(NEW_FEATURE_DEPTH)) ? CW'(NEW_FEATURE_DEPTH) : feat_count;
  assign start_acc = (state_q == IDLE) && start;
  assign active    = (state_q == READ) || (state_q == DRAIN);
  assign hs        = tvalid_q && m_tready;

  always_comb begin
    in_flight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) in_flight = in_flight + FCW'(vld_pipe_q[i]);
  end

  // Reserve a FIFO slot for every read still in the BRAM pipe.
  assign credit   = ({1'b0, in_flight} + {1'b0, fifo_count}) < (FCW+1)'(FIFO_DEPTH);
  assign issue    = (state_q == READ) && (issued_q != cnt_q) && credit;
  assign pop      = active && (fifo_count != '0) && (!tvalid_q || m_tready);
  assign last_pop = pop && ((popped_q + CW'(1)) == cnt_q);

  gat_feat_rd_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_pipe_q[RD_LATENCY]),
    .din_i   (feat_bram_dout[DATA_WIDTH-1:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (cnt_clamp == '0) ? DONE : READ;
      READ:  if (issued_q == cnt_q) state_d = DRAIN;
      DRAIN: if (hs && tlast_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    feat_bram_enb   = issue;
    feat_bram_addrb = issue ? {issued_q[NEW_FEATURE_ADDR_W-1:0], 2'b00} : '0;
  end

  // Lanes above the current one are always zero, so a short final word pads itself.
  always_comb begin
    word_d         = lanes_q;
    word_d[lane_q] = fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      vld_pipe_q <= '0;
      lanes_q    <= '0;
      lane_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        cnt_q    <= cnt_clamp;
        issued_q <= '0;
        popped_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + CW'(1);
      end
      vld_pipe_q[1] <= issue;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      if (hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      if (pop) begin
        popped_q <= popped_q + CW'(1);
        if ((lane_q == LW'(PACK - 1)) || last_pop) begin
          tdata_q  <= word_d;
          tvalid_q <= 1'b1;
          tlast_q  <= last_pop;
          lanes_q  <= '0;
          lane_q   <= '0;
        end else begin
          lanes_q <= word_d;
          lane_q  <= lane_q + LW'(1);
        end
      end
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
endmodule
